// File: rtl/cmp_minmax_tracker.sv
// Frame-based running min/max tracker behind the 4-bit magnitude comparator.
// Define CMP_MINMAX_IDX_EN to add out_min_idx/out_max_idx frame-position outputs.
module cmp_minmax_tracker #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max
`ifdef CMP_MINMAX_IDX_EN
    ,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_max_idx
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(FRAME_LEN - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef CMP_MINMAX_IDX_EN
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
`endif

    logic accept;
    logic consume;
    logic is_lt;
    logic is_gt;

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;
    assign is_lt   = in_data < min_q;
    assign is_gt   = in_data > max_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        min_d   = min_q;
        max_d   = max_q;
`ifdef CMP_MINMAX_IDX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        // clr outranks accept and consume; the sample in the clr cycle is dropped
        if (clr) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        min_d   = in_data;
                        max_d   = in_data;
                        count_d = CNT_ONE;
`ifdef CMP_MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        state_d = (FRAME_LEN == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        // strict compares keep the earliest occurrence on ties
                        if (is_lt) begin
                            min_d = in_data;
`ifdef CMP_MINMAX_IDX_EN
                            min_idx_d = count_q[IDX_W-1:0];
`endif
                        end
                        if (is_gt) begin
                            max_d = in_data;
`ifdef CMP_MINMAX_IDX_EN
                            max_idx_d = count_q[IDX_W-1:0];
`endif
                        end
                        count_d = count_q + CNT_ONE;
                        if (count_q == LAST_CNT) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
        // handshake flags are registered so no bypass path exists from out_ready to in_ready
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            min_q       <= '0;
            max_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q   <= '0;
            max_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            min_q       <= min_d;
            max_q       <= max_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q   <= min_idx_d;
            max_idx_q   <= max_idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
`ifdef CMP_MINMAX_IDX_EN
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Directed bench for cmp_minmax_tracker: default 8-sample instance plus a FRAME_LEN=1 instance.
// Index checks are compiled in when CMP_MINMAX_IDX_EN is defined.
module tb_cmp_minmax_tracker;

    logic       clk;
    logic       rst_n;
    logic       clr, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, out_min, out_max;
    logic       clr1, iv1, ir1, ov1, or1;
    logic [3:0] id1, mn1, mx1;
`ifdef CMP_MINMAX_IDX_EN
    logic [2:0] out_min_idx, out_max_idx;
    logic [2:0] mni1, mxi1;
`endif

    int n_vec;
    int n_fail;

    cmp_minmax_tracker #(.WIDTH(4), .FRAME_LEN(8), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max)
`ifdef CMP_MINMAX_IDX_EN
        , .out_min_idx(out_min_idx), .out_max_idx(out_max_idx)
`endif
    );

    cmp_minmax_tracker #(.WIDTH(4), .FRAME_LEN(1), .IDX_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1),
        .out_min(mn1), .out_max(mx1)
`ifdef CMP_MINMAX_IDX_EN
        , .out_min_idx(mni1), .out_max_idx(mxi1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;     // sample i in d[4*i +: 4]
        logic [3:0]  mn;
        logic [3:0]  mx;
        logic [2:0]  mni;
        logic [2:0]  mxi;
        bit          gaps;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic run_frame(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            if (v.gaps) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            if (i == 0) chk("in_ready_frame_start", in_ready, 1);
            if (i == 7) chk("out_valid_before_last", out_valid, 0);
            send(v.d[4*i +: 4]);
        end
        chk("out_valid_latency", out_valid, 1);
        chk("out_min", out_min, v.mn);
        chk("out_max", out_max, v.mx);
`ifdef CMP_MINMAX_IDX_EN
        chk("out_min_idx", out_min_idx, v.mni);
        chk("out_max_idx", out_max_idx, v.mxi);
`endif
        // offer a zero sample while the result is held; it must not be taken
        in_valid = 1'b1;
        in_data  = 4'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_min_stable", out_min, v.mn);
            chk("hold_max_stable", out_max, v.mx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        clr1 = 1'b0; iv1 = 1'b0; id1 = 4'd0; or1 = 1'b0;

        tbl[0] = '{32'h97F03935, 4'd0,  4'd15, 3'd4, 3'd5, 1'b0};
        tbl[1] = '{32'h88888888, 4'd8,  4'd8,  3'd0, 3'd0, 1'b0};
        tbl[2] = '{32'h87654321, 4'd1,  4'd8,  3'd0, 3'd7, 1'b0};
        tbl[3] = '{32'h12345678, 4'd1,  4'd8,  3'd7, 3'd0, 1'b0};
        tbl[4] = '{32'h3330F0F7, 4'd0,  4'd15, 3'd2, 3'd1, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 4'd15, 4'd15, 3'd0, 3'd0, 1'b0};
        tbl[6] = '{32'h00000000, 4'd0,  4'd0,  3'd0, 3'd0, 1'b1};
        tbl[7] = '{32'h6E2E2BCA, 4'd2,  4'd14, 3'd3, 3'd4, 1'b1};
        tbl[8] = '{32'h99999999, 4'd9,  4'd9,  3'd0, 3'd0, 1'b1};

        // reset state
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_min", out_min, 0);
        chk("rst_out_max", out_max, 0);
        rst_n = 1'b1;
        #1;
        chk("pre_edge_in_ready", in_ready, 0);
        tick();
        chk("post_edge_in_ready", in_ready, 1);

        for (int f = 0; f < 9; f++) begin
            run_frame(tbl[f]);
        end

        // clr discards a partial frame; the sample in the clr cycle is dropped
        send(4'd2); send(4'd4); send(4'd6); send(4'd1);
        clr = 1'b1; in_valid = 1'b1; in_data = 4'd0;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        run_frame(tbl[8]);

        // clr while holding a result, with out_ready also high
        for (int i = 0; i < 8; i++) send(4'd3);
        chk("hold_before_clr", out_valid, 1);
        clr = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0; out_ready = 1'b0;
        chk("clr_hold_out_valid", out_valid, 0);
        chk("clr_hold_in_ready", in_ready, 1);
        run_frame(tbl[2]);

        // async reset between edges mid-frame
        send(4'd7); send(4'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_min", out_min, 0);
        chk("async_rst_max", out_max, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("after_rst_in_ready", in_ready, 1);
        begin
            vec_t v;
            v = '{32'h4444440F, 4'd0, 4'd15, 3'd1, 3'd0, 1'b0};
            run_frame(v);
        end

        // FRAME_LEN=1 instance: alternating accept and consume
        begin
            logic [15:0] seq;
            logic [3:0]  s;
            seq = 16'h9F06;
            for (int i = 0; i < 4; i++) begin
                s = seq[4*i +: 4];
                chk("f1_in_ready", ir1, 1);
                iv1 = 1'b1; id1 = s;
                tick();
                chk("f1_out_valid", ov1, 1);
                chk("f1_min", mn1, s);
                chk("f1_max", mx1, s);
`ifdef CMP_MINMAX_IDX_EN
                chk("f1_min_idx", mni1, 0);
                chk("f1_max_idx", mxi1, 0);
`endif
                chk("f1_hold_in_ready", ir1, 0);
                id1 = ~s; or1 = 1'b1;
                tick();
                iv1 = 1'b0; or1 = 1'b0;
                chk("f1_consumed", ov1, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
